// File: rtl/seq_code_monitor.sv
// Checks the 3-bit sequence counter code stream (000,010,011,101,111), locks onto a clean sequence and counts laps.
// Optional SEQ_MON_STICKY_ERR_EN adds err_clr / err_sticky.
module seq_code_monitor #(
   parameter int unsigned LAP_W    = 8,
   parameter int unsigned LOCK_CNT = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [2:0]       code_in,
`ifdef SEQ_MON_STICKY_ERR_EN
   input  logic             err_clr,
   output logic             err_sticky,
`endif
   output logic [2:0]       step,
   output logic             step_valid,
   output logic             illegal,
   output logic             seq_err,
   output logic             locked,
   output logic [LAP_W-1:0] lap_cnt,
   output logic             lap_pulse
);

   typedef enum logic {UNLOCK, LOCKED} state_t;

   localparam logic [2:0] LOCK_V = 3'(LOCK_CNT);

   state_t           state, state_nx;
   logic             prev_valid, prev_valid_nx;
   logic [2:0]       good_cnt, good_nx;
   logic [2:0]       step_nx;
   logic             sv_nx, ill_nx, serr_nx, lp_nx;
   logic [LAP_W-1:0] lap_nx;
   logic             cur_legal;
   logic [2:0]       cur_idx, succ_idx;

   always_comb begin
      cur_legal = 1'b1;
      cur_idx   = '0;
      case (code_in)
         3'b000:  cur_idx = 3'd0;
         3'b010:  cur_idx = 3'd1;
         3'b011:  cur_idx = 3'd2;
         3'b101:  cur_idx = 3'd3;
         3'b111:  cur_idx = 3'd4;
         default: cur_legal = 1'b0;
      endcase
   end

   // step always holds the index of the last legal sample, so it doubles as prev_code
   assign succ_idx = (step == 3'd4) ? 3'd0 : step + 3'd1;

   always_comb begin
      state_nx      = state;
      prev_valid_nx = prev_valid;
      good_nx       = good_cnt;
      step_nx       = step;
      lap_nx        = lap_cnt;
      sv_nx         = 1'b0;
      ill_nx        = 1'b0;
      serr_nx       = 1'b0;
      lp_nx         = 1'b0;
      if (en) begin
         if (!cur_legal) begin
            ill_nx        = 1'b1;
            prev_valid_nx = 1'b0;
            good_nx       = '0;
            if (state == LOCKED) begin
               serr_nx  = 1'b1;
               state_nx = UNLOCK;
            end
         end else begin
            step_nx       = cur_idx;
            sv_nx         = 1'b1;
            prev_valid_nx = 1'b1;
            if (!prev_valid) begin
               if (state == UNLOCK) good_nx = '0;
            end else if (cur_idx == step) begin
               // repeated code is a hold
            end else if (cur_idx == succ_idx) begin
               if (state == LOCKED) begin
                  if (cur_idx == 3'd0) begin
                     lap_nx = lap_cnt + LAP_W'(1);
                     lp_nx  = 1'b1;
                  end
               end else if (good_cnt >= LOCK_V - 3'd1) begin
                  good_nx  = LOCK_V;
                  state_nx = LOCKED;
               end else begin
                  good_nx = good_cnt + 3'd1;
               end
            end else begin
               good_nx = '0;
               if (state == LOCKED) begin
                  serr_nx  = 1'b1;
                  state_nx = UNLOCK;
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= UNLOCK;
         prev_valid <= 1'b0;
         good_cnt   <= '0;
         step       <= '0;
         step_valid <= 1'b0;
         illegal    <= 1'b0;
         seq_err    <= 1'b0;
         lap_cnt    <= '0;
         lap_pulse  <= 1'b0;
      end else begin
         state      <= state_nx;
         prev_valid <= prev_valid_nx;
         good_cnt   <= good_nx;
         step       <= step_nx;
         step_valid <= sv_nx;
         illegal    <= ill_nx;
         seq_err    <= serr_nx;
         lap_cnt    <= lap_nx;
         lap_pulse  <= lp_nx;
      end
   end

   assign locked = (state == LOCKED);

`ifdef SEQ_MON_STICKY_ERR_EN
   // a fresh error pulse beats a simultaneous clear
   always_ff @(posedge clk) begin
      if (!rst_n)                 err_sticky <= 1'b0;
      else if (illegal || seq_err) err_sticky <= 1'b1;
      else if (err_clr)           err_sticky <= 1'b0;
   end
`endif

endmodule

// File: tb/tb_seq_code_monitor.sv
// Self-checking bench for seq_code_monitor: directed scenarios plus randomized traffic against a behavioural model.
module tb_seq_code_monitor;

   localparam int LAP_W    = 2;
   localparam int LOCK_CNT = 3;

   logic             clk;
   logic             rst_n;
   logic             en;
   logic [2:0]       code_in;
   logic [2:0]       step;
   logic             step_valid, illegal, seq_err, locked, lap_pulse;
   logic [LAP_W-1:0] lap_cnt;
`ifdef SEQ_MON_STICKY_ERR_EN
   logic             err_clr;
   logic             err_sticky;
   bit               m_sticky;
`endif

   seq_code_monitor #(.LAP_W(LAP_W), .LOCK_CNT(LOCK_CNT)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .code_in    (code_in),
`ifdef SEQ_MON_STICKY_ERR_EN
      .err_clr    (err_clr),
      .err_sticky (err_sticky),
`endif
      .step       (step),
      .step_valid (step_valid),
      .illegal    (illegal),
      .seq_err    (seq_err),
      .locked     (locked),
      .lap_cnt    (lap_cnt),
      .lap_pulse  (lap_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [2:0] seq_codes [0:4] = '{3'b000, 3'b010, 3'b011, 3'b101, 3'b111};

   // model state
   int m_prev;   // index of last legal sample, -1 when none
   int m_good;
   int m_laps;
   int m_step;
   bit m_locked;
   bit e_sv, e_ill, e_serr, e_lp;

   logic [LAP_W+7:0] outv;
   assign outv = {step, step_valid, illegal, seq_err, locked, lap_cnt, lap_pulse};

   function automatic int code_idx(input logic [2:0] c);
      for (int i = 0; i < 5; i++)
         if (seq_codes[i] == c) return i;
      return -1;
   endfunction

   function automatic logic [LAP_W+7:0] exp_vec();
      return {3'(m_step), e_sv, e_ill, e_serr, m_locked, LAP_W'(m_laps), e_lp};
   endfunction

   task automatic model_reset();
      m_prev = -1; m_good = 0; m_laps = 0; m_step = 0; m_locked = 0;
      e_sv = 0; e_ill = 0; e_serr = 0; e_lp = 0;
`ifdef SEQ_MON_STICKY_ERR_EN
      m_sticky = 0;
`endif
   endtask

   task automatic do_reset();
      rst_n   = 1'b0;
      en      = 1'b1;
      code_in = 3'($urandom);
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic drive(input bit e, input logic [2:0] c);
      int idx;
      en = e; code_in = c;
`ifdef SEQ_MON_STICKY_ERR_EN
      if (e_ill || e_serr) m_sticky = 1;
      else if (err_clr)    m_sticky = 0;
`endif
      e_sv = 0; e_ill = 0; e_serr = 0; e_lp = 0;
      if (e) begin
         idx = code_idx(c);
         if (idx < 0) begin
            e_ill = 1;
            if (m_locked) begin e_serr = 1; m_locked = 0; end
            m_good = 0;
            m_prev = -1;
         end else begin
            m_step = idx;
            e_sv   = 1;
            if (m_prev < 0) begin
               if (!m_locked) m_good = 0;
            end else if (idx == m_prev) begin
               // hold
            end else if (idx == (m_prev + 1) % 5) begin
               if (m_locked) begin
                  if (idx == 0) begin
                     m_laps = (m_laps + 1) % (1 << LAP_W);
                     e_lp = 1;
                  end
               end else begin
                  m_good++;
                  if (m_good >= LOCK_CNT) m_locked = 1;
               end
            end else begin
               m_good = 0;
               if (m_locked) begin e_serr = 1; m_locked = 0; end
            end
            m_prev = idx;
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++;
      if (outv !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h expected 0", outv);
      end
`ifdef SEQ_MON_STICKY_ERR_EN
      n_cmp++;
      if (err_sticky !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_sticky: got %b expected 0", err_sticky);
      end
`endif
   endtask

   task automatic test_lap();
      for (int i = 0; i < 6; i++) begin
         drive(1, seq_codes[i % 5]);
         n_cmp++;
         if (outv !== exp_vec()) begin
            n_fail++;
            $display("FAIL lap_model[%0d]: got %h expected %h", i, outv, exp_vec());
         end
         n_cmp++;
         if (step !== 3'(i % 5) || step_valid !== 1'b1 || locked !== (i >= 3)) begin
            n_fail++;
            $display("FAIL lap_step[%0d]: got step=%0d sv=%b locked=%b expected step=%0d sv=1 locked=%b",
                     i, step, step_valid, locked, i % 5, i >= 3);
         end
      end
      n_cmp++;
      if (lap_cnt !== LAP_W'(1) || lap_pulse !== 1'b1) begin
         n_fail++;
         $display("FAIL lap_count: got lap_cnt=%0d pulse=%b expected 1/1", lap_cnt, lap_pulse);
      end
   endtask

   task automatic test_illegal();
      drive(1, 3'b110);
      n_cmp++;
      if (outv !== exp_vec()) begin
         n_fail++;
         $display("FAIL illegal_model: got %h expected %h", outv, exp_vec());
      end
      n_cmp++;
      if ({illegal, seq_err, locked, step_valid} !== 4'b1100 || step !== 3'd0 || lap_cnt !== LAP_W'(1)) begin
         n_fail++;
         $display("FAIL illegal_flags: got ill=%b serr=%b lock=%b sv=%b step=%0d lap=%0d expected 1 1 0 0 0 1",
                  illegal, seq_err, locked, step_valid, step, lap_cnt);
      end
   endtask

   task automatic test_skip();
      logic [2:0] pre [0:7] = '{3'b000, 3'b010, 3'b011, 3'b101, 3'b111, 3'b000, 3'b010, 3'b101};
      logic [2:0] post [0:2] = '{3'b111, 3'b000, 3'b010};
      for (int i = 0; i < 8; i++) begin
         drive(1, pre[i]);
         n_cmp++;
         if (outv !== exp_vec()) begin
            n_fail++;
            $display("FAIL skip_model[%0d]: got %h expected %h", i, outv, exp_vec());
         end
      end
      n_cmp++;
      if ({seq_err, illegal, locked} !== 3'b100) begin
         n_fail++;
         $display("FAIL skip_flags: got serr=%b ill=%b lock=%b expected 1 0 0", seq_err, illegal, locked);
      end
      for (int i = 0; i < 3; i++) begin
         drive(1, post[i]);
         n_cmp++;
         if (locked !== (i == 2) || seq_err !== 1'b0) begin
            n_fail++;
            $display("FAIL skip_relock[%0d]: got lock=%b serr=%b expected lock=%b serr=0", i, locked, seq_err, i == 2);
         end
      end
   endtask

   task automatic test_gap();
      for (int i = 0; i < 4; i++) begin
         drive(0, 3'($urandom));
         n_cmp++;
         if ({step_valid, illegal, seq_err, lap_pulse} !== 4'b0000 || locked !== 1'b1 || outv !== exp_vec()) begin
            n_fail++;
            $display("FAIL gap_hold[%0d]: got %h expected %h", i, outv, exp_vec());
         end
      end
      drive(1, 3'b011);
      n_cmp++;
      if (seq_err !== 1'b0 || locked !== 1'b1 || step !== 3'd2 || step_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL gap_resume: got serr=%b lock=%b step=%0d sv=%b expected 0 1 2 1", seq_err, locked, step, step_valid);
      end
   endtask

   task automatic test_wrap();
      int lap_no;
      lap_no = 0;
      do_reset();
      for (int i = 0; i < 21; i++) begin
         drive(1, seq_codes[i % 5]);
         if (i > 0 && i % 5 == 0) begin
            lap_no++;
            n_cmp++;
            if (lap_cnt !== LAP_W'(lap_no % 4) || lap_pulse !== 1'b1) begin
               n_fail++;
               $display("FAIL wrap_lap%0d: got lap_cnt=%0d pulse=%b expected %0d/1", lap_no, lap_cnt, lap_pulse, lap_no % 4);
            end
         end
      end
      for (int i = 0; i < 5; i++) begin
         drive(1, (i == 0) ? 3'b010 : (i == 4) ? 3'b101 : 3'b011);
         n_cmp++;
         if (seq_err !== 1'b0 || locked !== 1'b1 || outv !== exp_vec()) begin
            n_fail++;
            $display("FAIL wrap_repeat[%0d]: got %h expected %h", i, outv, exp_vec());
         end
      end
   endtask

   task automatic test_reset_mid();
      n_cmp++;
      if (locked !== 1'b1) begin
         n_fail++;
         $display("FAIL midreset_pre: got lock=%b expected 1", locked);
      end
      do_reset();
      n_cmp++;
      if (outv !== '0) begin
         n_fail++;
         $display("FAIL midreset_outputs: got %h expected 0", outv);
      end
   endtask

`ifdef SEQ_MON_STICKY_ERR_EN
   task automatic test_sticky();
      do_reset();
      drive(1, 3'b110);
      n_cmp++;
      if (illegal !== 1'b1 || err_sticky !== 1'b0) begin
         n_fail++;
         $display("FAIL sticky_pre: got ill=%b sticky=%b expected 1 0", illegal, err_sticky);
      end
      err_clr = 1'b1;
      drive(0, 3'b000);
      n_cmp++;
      if (err_sticky !== 1'b1) begin
         n_fail++;
         $display("FAIL sticky_setwins: got %b expected 1", err_sticky);
      end
      drive(0, 3'b000);
      n_cmp++;
      if (err_sticky !== 1'b0) begin
         n_fail++;
         $display("FAIL sticky_clear: got %b expected 0", err_sticky);
      end
      err_clr = 1'b0;
   endtask
`endif

   task automatic test_random();
      int r;
      logic [2:0] c;
      for (int i = 0; i < 400; i++) begin
         r = int'($urandom_range(0, 99));
         if (m_prev < 0 || r < 8)  c = 3'($urandom);
         else if (r < 18)          c = seq_codes[m_prev];
         else if (r < 26)          c = seq_codes[$urandom_range(0, 4)];
         else                      c = seq_codes[(m_prev + 1) % 5];
`ifdef SEQ_MON_STICKY_ERR_EN
         err_clr = ($urandom_range(0, 3) == 0);
`endif
         drive($urandom_range(0, 9) != 0, c);
         n_cmp++;
         if (outv !== exp_vec()) begin
            n_fail++;
            $display("FAIL random[%0d]: got %h expected %h", i, outv, exp_vec());
         end
`ifdef SEQ_MON_STICKY_ERR_EN
         n_cmp++;
         if (err_sticky !== m_sticky) begin
            n_fail++;
            $display("FAIL random_sticky[%0d]: got %b expected %b", i, err_sticky, m_sticky);
         end
`endif
      end
`ifdef SEQ_MON_STICKY_ERR_EN
      err_clr = 1'b0;
`endif
   endtask

   initial begin
      rst_n   = 1'b0;
      en      = 1'b0;
      code_in = '0;
`ifdef SEQ_MON_STICKY_ERR_EN
      err_clr = 1'b0;
`endif
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_lap();
      test_illegal();
      test_skip();
      test_gap();
      test_wrap();
      test_reset_mid();
`ifdef SEQ_MON_STICKY_ERR_EN
      test_sticky();
`endif
      do_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
